// File: rtl/processor18_pkg.sv
// processor18_pkg: definitions shared by the 18-bit processor, its code RAM
// and the code loader.
//   WORD_SIZE              instruction word width (18 bits)
//   LOADER_BYTES_PER_WORD  stream bytes per instruction word
//   loader_state_t         code loader FSM states
// Optional feature macro: CODE_LOADER_CHECKSUM_EN adds the S_CSUM state.
package processor18_pkg;

    localparam int WORD_SIZE             = 18;
    localparam int LOADER_BYTES_PER_WORD = 3;

    typedef enum logic [3:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/code_loader_asm.sv
// code_loader_asm: byte-to-word assembler for the code loader.
// Collects b0/b1/b2 of a big-endian 3-byte word into an 18-bit register.
//   clock, reset   system clock, async active-high reset
//   byte_i         stream byte
//   load_i         shift byte_i into the word register
//   first_i        byte_i is b0 (only its low two bits are kept)
//   word_o         assembled word {b0[1:0], b1, b2}
//   hi_bad_o       byte_i[7:2] non-zero (malformed b0 when first_i)
module code_loader_asm
    import processor18_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           byte_i,
    input  logic                 load_i,
    input  logic                 first_i,
    output logic [WORD_SIZE-1:0] word_o,
    output logic                 hi_bad_o
);

    logic [WORD_SIZE-1:0] word_q;
    logic [WORD_SIZE-1:0] word_d;

    // b0 seeds the low bits; b1 and b2 each shift 8 bits in, so after b2
    // the register holds {b0[1:0], b1, b2}.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            if (first_i) word_d = {16'h0000, byte_i[1:0]};
            else         word_d = {word_q[9:0], byte_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
    end

    assign word_o   = word_q;
    assign hi_bad_o = (byte_i[7:2] != 6'd0);

endmodule

// File: rtl/code_loader.sv
// code_loader: writes a byte-streamed program image into the 18-bit code RAM
// and holds the processor in reset until a complete, valid image is loaded.
// Stream: 16-bit big-endian word count N, then N words of 3 bytes each.
//   clock, reset         system clock, async active-high reset
//   rx_valid/rx_data     incoming byte; rx_ready accepts it
//   start                restart pulse, honoured in S_DONE / S_ERROR only
//   mem_we/addr/din      code RAM write port, one strobe per word
//   cpu_reset            processor reset, low only in S_DONE
//   complete / error     load status levels
// Optional feature macro: CODE_LOADER_CHECKSUM_EN appends an XOR trailer
// byte checked in S_CSUM.
module code_loader
    import processor18_pkg::*;
#(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = processor18_pkg::WORD_SIZE,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    input  logic                 start,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_din,
    output logic                 cpu_reset,
    output logic                 complete,
    output logic                 error
);

    // State entered once the last word (or an empty image) is in.
`ifdef CODE_LOADER_CHECKSUM_EN
    localparam loader_state_t S_FINAL = S_CSUM;
`else
    localparam loader_state_t S_FINAL = S_DONE;
`endif

    loader_state_t        state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    logic accept;
    logic asm_load, asm_first, asm_hi_bad;

    code_loader_asm u_asm (
        .clock    (clock),
        .reset    (reset),
        .byte_i   (rx_data),
        .load_i   (asm_load),
        .first_i  (asm_first),
        .word_o   (mem_din),
        .hi_bad_o (asm_hi_bad)
    );

    assign accept = rx_valid && rx_ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        asm_load  = 1'b0;
        asm_first = 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        if (accept && state_q != S_CSUM) xor_d = xor_q ^ rx_data;
`endif
        case (state_q)
            S_LEN_HI: if (accept) begin
                len_d   = {rx_data, 8'h00};
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d = {len_q[15:8], rx_data};
                if ({len_q[15:8], rx_data} == 16'd0)
                    state_d = S_FINAL;
                else if (int'({len_q[15:8], rx_data}) > MEM_SIZE)
                    state_d = S_ERROR;
                else
                    state_d = S_B0;
            end
            S_B0: if (accept) begin
                if (asm_hi_bad) begin
                    state_d = S_ERROR;
                end else begin
                    asm_load  = 1'b1;
                    asm_first = 1'b1;
                    state_d   = S_B1;
                end
            end
            S_B1: if (accept) begin
                asm_load = 1'b1;
                state_d  = S_B2;
            end
            S_B2: if (accept) begin
                asm_load = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_SIZE'(1);
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_q + 16'd1 == len_q) ? S_FINAL : S_B0;
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CSUM: if (accept) begin
                state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: if (start) begin
                state_d = S_LEN_HI;
                len_d   = '0;
                cnt_d   = '0;
                addr_d  = '0;
`ifdef CODE_LOADER_CHECKSUM_EN
                xor_d   = '0;
`endif
            end
            default: state_d = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
`ifdef CODE_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    // Outputs decode the registered state, so mem_we rises the cycle after
    // b2 is accepted and the RAM captures on the edge leaving S_WRITE.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2: rx_ready = 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CSUM: rx_ready = 1'b1;
`endif
            default: rx_ready = 1'b0;
        endcase
    end

    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign complete  = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign cpu_reset = (state_q != S_DONE);

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        start;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [17:0] mem_din;
    logic        cpu_reset;
    logic        complete;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          wr_base;
    logic [35:0] sb[$];     // expected {addr, data} per RAM write
    logic [7:0]  bx;        // running XOR of stream bytes
    bit          gaps = 1'b0;
    logic        prev_we = 1'b0;

    code_loader dut (
        .clock     (clock),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .cpu_reset (cpu_reset),
        .complete  (complete),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe pops one expected write.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            chk("we_single_cycle", {35'd0, prev_we}, 36'd0);
            if (sb.size() == 0) chk("unexpected_write", 36'(sb.size()), 36'd1);
            else                chk("write_addr_data", {mem_addr, mem_din}, sb.pop_front());
        end
        prev_we <= mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit upd = 1'b1);
        int n = 0;
        if (gaps) while ($urandom_range(0, 1) == 1) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("rx_ready_timeout", {35'd0, rx_ready}, 36'd1);
        @(posedge clock);
        if (upd) bx = bx ^ b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_trailer();
`ifdef CODE_LOADER_CHECKSUM_EN
        send_byte(bx, 1'b0);
`endif
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_status(input string tag, input logic c, input logic e, input logic r);
        chk({tag, "_complete"},  {35'd0, complete},  {35'd0, c});
        chk({tag, "_error"},     {35'd0, error},     {35'd0, e});
        chk({tag, "_cpu_reset"}, {35'd0, cpu_reset}, {35'd0, r});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bx = 8'h00;
        chk_status("after_start", 1'b0, 1'b0, 1'b1);
        chk("after_start_rx_ready", {35'd0, rx_ready}, 36'd1);
    endtask

    task automatic image_two_words();
        bx = 8'h00;
        sb.push_back({18'd0, 18'h12345});
        sb.push_back({18'd1, 18'h3FFFF});
        wr_base = wr_cnt;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
        send_trailer();
        settle();
        chk_status("two_words", 1'b1, 1'b0, 1'b0);
        chk("two_words_count", 36'(wr_cnt - wr_base), 36'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},       {35'd0, mem_we},   36'd0);
        chk({tag, "_addr"},     {18'd0, mem_addr}, 36'd0);
        chk({tag, "_din"},      {18'd0, mem_din},  36'd0);
        chk({tag, "_rx_ready"}, {35'd0, rx_ready}, 36'd1);
        chk_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        bx       = 8'h00;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Two-word image
        image_two_words();
        pulse_start();

        // Empty image
        wr_base = wr_cnt;
        send_byte(8'h00); send_byte(8'h00);
        send_trailer();
        settle();
        chk_status("empty", 1'b1, 1'b0, 1'b0);
        chk("empty_no_write", 36'(wr_cnt - wr_base), 36'd0);
        pulse_start();

        // Oversize count N=1025
        wr_base = wr_cnt;
        send_byte(8'h04); send_byte(8'h01);
        settle();
        chk_status("oversize", 1'b0, 1'b1, 1'b1);
        chk("oversize_rx_ready", {35'd0, rx_ready}, 36'd0);
        pulse_start();

        // Malformed b0
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h04);
        settle();
        chk_status("bad_b0", 1'b0, 1'b1, 1'b1);
        chk("bad_b0_no_write", 36'(wr_cnt - wr_base), 36'd0);
        pulse_start();

        // Same image with random rx_valid gaps
        gaps = 1'b1;
        image_two_words();
        gaps = 1'b0;
        pulse_start();

        // N == MEM_SIZE is legal: loader waits for b0
        send_byte(8'h04); send_byte(8'h00);
        settle();
        chk("max_len_error", {35'd0, error}, 36'd0);
        chk("max_len_rx_ready", {35'd0, rx_ready}, 36'd1);
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bx = 8'h00;

        // Asynchronous reset mid-word
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("async_reset");
        @(negedge clock);
        reset = 1'b0;
        bx = 8'h00;
        sb.push_back({18'd0, 18'h00007});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        send_trailer();
        settle();
        chk_status("after_reset", 1'b1, 1'b0, 1'b0);

`ifdef CODE_LOADER_CHECKSUM_EN
        // Explicit trailers: correct XOR is 06
        pulse_start();
        sb.push_back({18'd0, 18'h00007});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h06, 1'b0);
        settle();
        chk_status("csum_good", 1'b1, 1'b0, 1'b0);
        pulse_start();
        sb.push_back({18'd0, 18'h00007});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h05, 1'b0);
        settle();
        chk_status("csum_bad", 1'b0, 1'b1, 1'b1);
`endif

        chk("scoreboard_drained", 36'(sb.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
- Writer end of the program-memory interface: receives a byte stream (host/UART side) and writes 18-bit instruction words into the code RAM that the processor fetches from.
- Holds the processor in reset until a complete, valid image has been written, then releases it.
- Sits between the byte receiver and the code RAM write port; the processor's fetch port is untouched.

Parameters:
- ADDR_SIZE, 18, width of mem_addr.
- WORD_SIZE, 18, width of mem_din; fixed at 18, since 3 bytes carry 18 bits.
- MEM_SIZE, 1024, code RAM depth in words; upper bound for the word count.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte; a transfer occurs on a clock edge with rx_valid && rx_ready.
- start  in  1  one-cycle pulse; restarts a load from S_DONE or S_ERROR and is ignored otherwise.
- mem_we  out  1  code RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_SIZE  write address.
- mem_din  out  WORD_SIZE  write data.
- cpu_reset  out  1  processor reset; high unless state is S_DONE.
- complete  out  1  image loaded; level signal.
- error  out  1  load aborted; level signal.

Behaviour:
- Stream format, all fields big-endian:
  - Bytes 1-2: word count N, 16 bits.
  - Then N words of 3 bytes each: b0[1:0] = word[17:16], b1 = word[15:8], b2 = word[7:0].
- States: S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_WRITE, (S_CSUM), S_DONE, S_ERROR.
- Reset (asynchronous):
  - State goes to S_LEN_HI; word counter and address counter go to 0.
  - Outputs: mem_we=0, mem_addr=0, mem_din=0, complete=0, error=0, cpu_reset=1, rx_ready=1.
- rx_ready is 1 in S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2 and S_CSUM; it is 0 in every other state. State advances only on an accepted byte; rx_valid=0 stalls indefinitely with no timeout.
- S_LEN_LO:
  - After the low byte is accepted, N is latched.
  - N==0 → S_DONE (or S_CSUM if checksum enabled).
  - N>MEM_SIZE → S_ERROR.
  - Otherwise → S_B0.
- S_B0: if rx_data[7:2]!=0 on acceptance → S_ERROR. Malformed word; nothing is written.
- S_B2 → S_WRITE. In S_WRITE:
  - mem_we=1 for exactly one cycle.
  - mem_din = assembled word; mem_addr = address counter.
  - Registered outputs: mem_we is asserted the cycle after the third byte is accepted.
- Leaving S_WRITE:
  - Address counter increments.
  - If this was word N → S_DONE (or S_CSUM); otherwise → S_B0.
- Sustained throughput: 1 word per 4 cycles. The RAM write completes on the edge that ends S_WRITE.
- S_DONE: complete=1, cpu_reset=0.
- S_ERROR: error=1, cpu_reset=1. RAM contents are partially overwritten and are undefined to the processor.
- start in S_DONE/S_ERROR:
  - Clears complete/error and both counters.
  - Goes to S_LEN_HI and raises cpu_reset on the next cycle.
- Reset asserted mid-load aborts immediately; there is no recovery of partial state.
- Address never wraps: N≤MEM_SIZE guarantees mem_addr ≤ MEM_SIZE-1.

Optional Feature:
- Macro: CODE_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or after the length when N==0), state S_CSUM accepts one byte.
  - That byte must equal the XOR of every preceding stream byte, length bytes included.
  - Match → S_DONE; mismatch → S_ERROR.
  - The running XOR register clears on reset/start.
- Not defined: S_CSUM and the XOR register are absent; the final S_WRITE goes directly to S_DONE.

Decomposition:
- Shared package processor18_pkg:
  - loader_state_t enum.
  - LOADER_BYTES_PER_WORD=3.
  - WORD_SIZE constant shared with processor and RAM.
- Optional sub-module code_loader_asm: a byte-to-word assembler, holding the shift register for b0/b1/b2 plus the b0 upper-bit check.
- The FSM and counters stay in code_loader.

Test Plan:
- N=2, stream 00 02 | 01 23 45 | 03 FF FF → writes at addr 0 = 0x12345 and addr 1 = 0x3FFFF, one mem_we pulse each. Then complete=1, cpu_reset=0, error=0.
- N=0, stream 00 00 → S_DONE. mem_we is never asserted; complete=1.
- N=1025 (MEM_SIZE=1024), stream 04 01 → error=1, cpu_reset=1, no writes; start pulse → back to accepting length, error=0.
- Malformed b0, stream 00 01 | 04 00 00 → error=1, no write. rx_valid toggled randomly during the legal stream of test 1 → identical writes.
- Reset asserted after 00 03 01 → all outputs at reset values asynchronously; a fresh stream 00 01 00 00 07 → addr 0 = 0x00007.
- With CODE_LOADER_CHECKSUM_EN, stream 00 01 00 00 07 then 06 → complete=1. The same stream with trailer 05 → error=1.
